// File: rtl/servo_pwm_card_if.sv
// SPI command bus of the servo slot card: the decoded command, the slot
// address, the payload and a one-cycle strobe produced by the slot's SPI
// command decoder.
//   spi_cmd_r        16-bit decoded command code
//   spi_addr_r       8-bit slot address of the command
//   spi_data_r       40-bit payload
//   spi_data_valid_r one-cycle strobe, fields are valid while it is high
// Handshake: there is no back-pressure. The card samples every field on the
// rising clock edge where spi_data_valid_r is 1, and each strobe is exactly one
// command. The master must hold every field stable during that cycle.
interface servo_pwm_card_if;
  logic [15:0] spi_cmd_r;
  logic [7:0]  spi_addr_r;
  logic [39:0] spi_data_r;
  logic        spi_data_valid_r;

  modport master (output spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r);
  modport slave  (input  spi_cmd_r, spi_addr_r, spi_data_r, spi_data_valid_r);
endinterface

// File: rtl/servo_pwm_card.sv
// servo_pwm_card: servo slot card with an internal PWM generator, debounced
// limit-aware drive gating, a latched emergency stop and an x4 quadrature
// position counter.
// Optional build macro: SERVO_SOFT_START_EN makes the active duty ramp by one
// step per PWM period instead of jumping to the written value.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   spi                    command bus (servo_pwm_card_if.slave)
//   MODE, MODE1            driven 1 when the card is enabled, else Z
//   ul, ll                 raw limit switches, high = on limit
//   Phase                  direction output, 1 = toward ul (Z when disabled)
//   Enable                 PWM drive output (Z when disabled)
//   OW_ID                  one-wire ID line, pulled low while tx_slot==0
//   quad_a, quad_b         raw encoder inputs
//   quad_a_out, quad_b_out synchronised encoder pass-through (Z when disabled)
//   ul_out, ll_out         debounced limits (Z when disabled)
//   position               signed quadrature count
//   quad_err               sticky illegal-transition flag
//   fault                  high in the ESTOP state
//   uart_slot_en           one-wire UART slot select
//   rx_slot, tx_slot       one-wire receive / transmit
//   EM_STOP                emergency stop input, active high
//   dbg_state              current FSM state (DISABLED=0 RUN=1 BLOCKED=2 ESTOP=3)
`ifndef DISABLED_MODE
`define DISABLED_MODE 3'd0
`endif
`ifndef ONE_WIRE_MODE
`define ONE_WIRE_MODE 3'd1
`endif
`ifndef C_SET_ENABLE_SERVO_CARD
`define C_SET_ENABLE_SERVO_CARD 16'h0030
`endif
`ifndef C_SET_SERVO_CARD_PHASE
`define C_SET_SERVO_CARD_PHASE 16'h0031
`endif
`ifndef C_SET_SERVO_PWM_PERIOD
`define C_SET_SERVO_PWM_PERIOD 16'h0032
`endif
`ifndef C_SET_SERVO_PWM_DUTY
`define C_SET_SERVO_PWM_DUTY 16'h0033
`endif
`ifndef C_SET_SERVO_POSITION
`define C_SET_SERVO_POSITION 16'h0034
`endif
`ifndef C_CLR_SERVO_FAULT
`define C_CLR_SERVO_FAULT 16'h0035
`endif

module servo_pwm_card #(
  parameter int DEV_ID             = 0,
  parameter int UART_ADDRESS_WIDTH = 0,
  parameter int PWM_WIDTH          = 16,
  parameter int CNT_WIDTH          = 32,
  parameter int DEBOUNCE_CYCLES    = 64,
  // A zero-width select is kept as one bit so the port stays legal.
  localparam int UW = (UART_ADDRESS_WIDTH < 1) ? 1 : UART_ADDRESS_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  servo_pwm_card_if.slave      spi,
  output wire                  MODE,
  output wire                  MODE1,
  input  logic                 ul,
  input  logic                 ll,
  output wire                  Phase,
  inout  wire                  OW_ID,
  output wire                  Enable,
  input  logic                 quad_a,
  input  logic                 quad_b,
  output wire                  quad_a_out,
  output wire                  quad_b_out,
  output wire                  ul_out,
  output wire                  ll_out,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 quad_err,
  output logic                 fault,
  input  logic [UW-1:0]        uart_slot_en,
  output wire                  rx_slot,
  input  logic                 tx_slot,
  input  logic                 EM_STOP,
  output logic [1:0]           dbg_state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [UW-1:0] OW_ADDR = UW'(DEV_ID + 7);

  typedef enum logic [1:0] {DISABLED = 2'd0, RUN = 2'd1, BLOCKED = 2'd2, ESTOP = 2'd3} state_t;

  state_t               state, next_state;
  logic [2:0]           mode;
  logic                 phase_r;
  logic [PWM_WIDTH-1:0] period_sh, duty_sh, period, duty_active, pwm_cnt;
  logic                 enable_q, estop_lat;
  logic [4:0]           sync1, sync2;      // {EM_STOP, ll, ul, quad_b, quad_a}
  logic                 a_p, b_p;
  logic [1:0]           lim_db;            // {ll_db, ul_db}
  logic [DBW-1:0]       db_cnt [2];

  logic unused_data;
  assign unused_data = ^spi.spi_data_r;

  // Command decode
  logic cmd_hit;
  assign cmd_hit = spi.spi_data_valid_r && (spi.spi_addr_r == 8'(DEV_ID));
  logic set_mode, set_phase, set_period, set_duty, set_pos, clr_fault;
  assign set_mode   = cmd_hit && (spi.spi_cmd_r == `C_SET_ENABLE_SERVO_CARD);
  assign set_phase  = cmd_hit && (spi.spi_cmd_r == `C_SET_SERVO_CARD_PHASE);
  assign set_period = cmd_hit && (spi.spi_cmd_r == `C_SET_SERVO_PWM_PERIOD);
  assign set_duty   = cmd_hit && (spi.spi_cmd_r == `C_SET_SERVO_PWM_DUTY);
  assign set_pos    = cmd_hit && (spi.spi_cmd_r == `C_SET_SERVO_POSITION);
  assign clr_fault  = cmd_hit && (spi.spi_cmd_r == `C_CLR_SERVO_FAULT);

  logic enabled, em_s, ul_db, ll_db, block;
  assign enabled = (mode > `ONE_WIRE_MODE);
  assign em_s    = sync2[4];
  assign ul_db   = lim_db[0];
  assign ll_db   = lim_db[1];
  assign block   = (phase_r && ul_db) || (!phase_r && ll_db);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode      <= `DISABLED_MODE;
      phase_r   <= 1'b0;
      period_sh <= '0;
      duty_sh   <= '0;
      sync1     <= '0;
      sync2     <= '0;
    end else begin
      if (set_mode)   mode      <= spi.spi_data_r[2:0];
      if (set_phase)  phase_r   <= spi.spi_data_r[0];
      if (set_period) period_sh <= spi.spi_data_r[PWM_WIDTH-1:0];
      if (set_duty)   duty_sh   <= spi.spi_data_r[PWM_WIDTH-1:0];
      sync1 <= {EM_STOP, ll, ul, quad_b, quad_a};
      sync2 <= sync1;
    end
  end

  // Limit debounce: the accepted level flips only after the synced input has
  // disagreed with it for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lim_db <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i+2] != lim_db[i]) begin
          if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            lim_db[i] <= sync2[i+2];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // PWM generator. Shadow registers take effect at the wrap, or immediately
  // while the generator is idle with period==0.
  logic wrap, pwm_load, pwm, run_entry;
  assign wrap      = (period != '0) && (pwm_cnt >= period - PWM_WIDTH'(1));
  assign pwm_load  = wrap || (period == '0);
  assign pwm       = (period != '0) && (pwm_cnt < duty_active);
  assign run_entry = (state != RUN) && (next_state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt     <= '0;
      period      <= '0;
      duty_active <= '0;
    end else begin
      pwm_cnt <= pwm_load ? '0 : pwm_cnt + 1'b1;
      if (pwm_load) period <= period_sh;
`ifdef SERVO_SOFT_START_EN
      if (run_entry) begin
        duty_active <= '0;
      end else if (pwm_load) begin
        if (duty_active < duty_sh)      duty_active <= duty_active + 1'b1;
        else if (duty_active > duty_sh) duty_active <= duty_active - 1'b1;
      end
`else
      if (pwm_load) duty_active <= duty_sh;
`endif
    end
  end

  // Drive state machine
  always_comb begin
    next_state = state;
    if (!enabled) begin
      next_state = DISABLED;
    end else begin
      case (state)
        DISABLED: next_state = estop_lat ? ESTOP : RUN;
        RUN:      if (em_s) next_state = ESTOP; else if (block) next_state = BLOCKED;
        BLOCKED:  if (em_s) next_state = ESTOP; else if (!block) next_state = RUN;
        ESTOP:    if (clr_fault && !em_s) next_state = RUN;
        default:  next_state = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= DISABLED;
      estop_lat <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state    <= next_state;
      enable_q <= (state == RUN) && pwm;
      // The latch survives a trip through DISABLED; only a real exit clears it.
      if (next_state == ESTOP)                         estop_lat <= 1'b1;
      else if (state == ESTOP && next_state == RUN)    estop_lat <= 1'b0;
    end
  end

  assign fault     = (state == ESTOP);
  assign dbg_state = state;

  // x4 quadrature decode on the synced encoder lines
  logic ch_a, ch_b, count_on, step_up;
  assign ch_a     = sync2[0] ^ a_p;
  assign ch_b     = sync2[1] ^ b_p;
  assign count_on = (state != DISABLED);
  assign step_up  = sync2[0] ^ b_p;   // valid when exactly one line changed

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_p      <= 1'b0;
      b_p      <= 1'b0;
      position <= '0;
      quad_err <= 1'b0;
    end else begin
      a_p <= sync2[0];
      b_p <= sync2[1];
      if (set_pos)
        position <= spi.spi_data_r[CNT_WIDTH-1:0];
      else if (count_on && (ch_a ^ ch_b))
        position <= step_up ? position + 1'b1 : position - 1'b1;
      if (count_on && ch_a && ch_b) quad_err <= 1'b1;
      else if (clr_fault)           quad_err <= 1'b0;
    end
  end

  // Slot pins
  logic ow_sel;
  assign ow_sel     = (uart_slot_en == OW_ADDR) && (mode > `DISABLED_MODE);
  assign OW_ID      = (ow_sel && !tx_slot) ? 1'b0 : 1'bz;
  assign rx_slot    = ow_sel ? OW_ID : 1'bz;
  assign MODE       = enabled ? 1'b1 : 1'bz;
  assign MODE1      = enabled ? 1'b1 : 1'bz;
  assign Phase      = enabled ? phase_r : 1'bz;
  assign Enable     = enabled ? enable_q : 1'bz;
  assign quad_a_out = enabled ? sync2[0] : 1'bz;
  assign quad_b_out = enabled ? sync2[1] : 1'bz;
  assign ul_out     = enabled ? ul_db : 1'bz;
  assign ll_out     = enabled ? ll_db : 1'bz;

endmodule
